l1_cache_ctrl: RTL and testbench

//  Direct-mapped L1 cache controller, upstream of the L2 cache. Accepts CPU read

---
 rtl/l1_cache_ctrl.sv | 147 ++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, read-only L1 cache controller sitting in front of an L2 cache.
// Serves hits locally and fills lines from L2 or, on an L2 miss, from main memory.
module l1_cache_ctrl #(
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [10:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_valid,
    output logic [31:0] cpu_data,
    output logic        cpu_hit,
    output logic        l1_miss,
    output logic [10:0] l2_addr,
    input  logic        l2_hit,
    input  logic        l2_miss,
    input  logic [31:0] l2_data,
    output logic        mem_req,
    output logic [10:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int NUM_BLOCKS = CACHE_SIZE / BLOCK_SIZE;
    localparam int OFF_W      = $clog2(BLOCK_SIZE);
    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int TAG_W      = 11 - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        L2_REQ   = 3'd2,
        L2_WAIT  = 3'd3,
        MEM_WAIT = 3'd4
    } state_t;

    state_t                  state_r;
    logic [NUM_BLOCKS-1:0]   valid_r;
    logic [TAG_W-1:0]        tag_r  [NUM_BLOCKS];
    logic [31:0]             data_r [NUM_BLOCKS];
    logic [10:0]             addr_r;
    logic                    cpu_valid_r;
    logic                    cpu_hit_r;
    logic [31:0]             cpu_data_r;
    logic [15:0]             hit_count_r;
    logic [15:0]             miss_count_r;

    logic [IDX_W-1:0]        idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic                    lookup_hit_s;

    assign idx_s        = addr_r[OFF_W +: IDX_W];
    assign tag_s        = addr_r[10 -: TAG_W];
    assign lookup_hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);

    // Handshake strobes are state decodes so an async reset drops them at once.
    assign cpu_ready  = (state_r == IDLE);
    assign l1_miss    = (state_r == L2_REQ);
    assign mem_req    = (state_r == MEM_WAIT);
    assign l2_addr    = addr_r;
    assign mem_addr   = addr_r;
    assign cpu_valid  = cpu_valid_r;
    assign cpu_hit    = cpu_hit_r;
    assign cpu_data   = cpu_data_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // Controller FSM, line storage, response registers and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            addr_r       <= 11'd0;
            cpu_valid_r  <= 1'b0;
            cpu_hit_r    <= 1'b0;
            cpu_data_r   <= 32'd0;
            hit_count_r  <= 16'd0;
            miss_count_r <= 16'd0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 32'd0;
            end
        end else begin
            cpu_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        addr_r  <= cpu_addr;
                        state_r <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit_s) begin
                        cpu_valid_r <= 1'b1;
                        cpu_hit_r   <= 1'b1;
                        cpu_data_r  <= data_r[idx_s];
                        if (hit_count_r != 16'hFFFF) begin
                            hit_count_r <= hit_count_r + 16'd1;
                        end
                        state_r <= IDLE;
                    end else begin
                        if (miss_count_r != 16'hFFFF) begin
                            miss_count_r <= miss_count_r + 16'd1;
                        end
                        state_r <= L2_REQ;
                    end
                end
                L2_REQ: begin
                    state_r <= L2_WAIT;
                end
                L2_WAIT: begin
                    // l2_hit takes priority; a missing answer is treated as an L2 miss.
                    if (l2_hit) begin
                        valid_r[idx_s] <= 1'b1;
                        tag_r[idx_s]   <= tag_s;
                        data_r[idx_s]  <= l2_data;
                        cpu_valid_r    <= 1'b1;
                        cpu_hit_r      <= 1'b0;
                        cpu_data_r     <= l2_data;
                        state_r        <= IDLE;
                    end else begin
                        state_r <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_valid) begin
                        valid_r[idx_s] <= 1'b1;
                        tag_r[idx_s]   <= tag_s;
                        data_r[idx_s]  <= mem_data;
                        cpu_valid_r    <= 1'b1;
                        cpu_hit_r      <= 1'b0;
                        cpu_data_r     <= mem_data;
                        state_r        <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: directed vector table, randomized reads
// against an array-based cache model, plus back-to-back, saturation and reset sequences.
module tb_l1_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [10:0] cpu_addr = 11'd0;
    logic        cpu_ready, cpu_valid, cpu_hit, l1_miss, mem_req;
    logic [31:0] cpu_data;
    logic [10:0] l2_addr, mem_addr;
    logic        l2_hit = 1'b0, l2_miss = 1'b0, mem_valid = 1'b0;
    logic [31:0] l2_data = 32'd0, mem_data = 32'd0;
    logic [15:0] hit_count, miss_count;

    int total = 0;
    int passed = 0;

    // Reference cache: 4 lines, index addr[6:5], tag addr[10:7].
    logic        m_valid [4];
    logic [3:0]  m_tag   [4];
    logic [31:0] m_data  [4];
    logic [15:0] m_hits, m_misses;

    typedef struct {
        logic [10:0] addr;
        int          mode;     // 0 l2_hit, 1 l2_miss, 2 no answer, 3 both asserted
        logic [31:0] l2d;
        int          md;       // cycles of mem_req before mem_valid
        logic [31:0] memd;
        logic        exp_hit;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t tbl[5];

    l1_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_hit(cpu_hit),
        .l1_miss(l1_miss), .l2_addr(l2_addr), .l2_hit(l2_hit), .l2_miss(l2_miss),
        .l2_data(l2_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
        .mem_data(mem_data), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 4'd0; m_data[i] = 32'd0;
        end
        m_hits = 16'd0; m_misses = 16'd0;
    endtask

    // Predict one read from the cache rules and update the model state.
    task automatic model_access(input logic [10:0] a, input int mode, input logic [31:0] l2d,
                                input int md, input logic [31:0] memd,
                                output logic hit, output logic [31:0] d, output int lat);
        int idx;
        idx = int'(a[6:5]);
        hit = m_valid[idx] && (m_tag[idx] == a[10:7]);
        if (hit) begin
            d = m_data[idx]; lat = 1;
            if (m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
        end else begin
            if (m_misses != 16'hFFFF) m_misses = m_misses + 16'd1;
            if (mode == 0 || mode == 3) begin d = l2d; lat = 3; end
            else begin d = memd; lat = 4 + md; end
            m_valid[idx] = 1'b1; m_tag[idx] = a[10:7]; m_data[idx] = d;
        end
    endtask

    // Issue one read, play the L2/memory side, and check the response.
    task automatic run_txn(input logic [10:0] a, input int mode, input logic [31:0] l2d,
                           input int md, input logic [31:0] memd, input logic exp_hit,
                           input logic [31:0] exp_d, input int exp_lat);
        int got_lat, miss_pulses, memreq_cycles;
        logic got_hit;
        logic [31:0] got_d;
        got_lat = -1; miss_pulses = 0; memreq_cycles = 0; got_hit = 1'b0; got_d = 32'd0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a;
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = $urandom_range(2047, 0);
        for (int c = 0; c < 60; c++) begin
            if (cpu_valid) begin
                got_lat = c; got_hit = cpu_hit; got_d = cpu_data;
                chk("ready_at_resp", {31'd0, cpu_ready}, 32'd1);
                break;
            end
            if (l1_miss) begin
                miss_pulses++;
                chk("l2_addr", {21'd0, l2_addr}, {21'd0, a});
            end
            if (mem_req) begin
                memreq_cycles++;
                chk("mem_addr", {21'd0, mem_addr}, {21'd0, a});
            end
            l2_hit = 1'b0; l2_miss = 1'b0; mem_valid = 1'b0;
            if (c == 2) begin
                l2_hit  = (mode == 0 || mode == 3);
                l2_miss = (mode == 1 || mode == 3);
                l2_data = l2d;
            end
            if (mem_req && memreq_cycles == md + 1) begin
                mem_valid = 1'b1; mem_data = memd;
            end
            @(negedge clk);
        end
        l2_hit = 1'b0; l2_miss = 1'b0; mem_valid = 1'b0;
        l2_data = $urandom; mem_data = $urandom;
        chk("latency", got_lat, exp_lat);
        chk("cpu_hit", {31'd0, got_hit}, {31'd0, exp_hit});
        chk("cpu_data", got_d, exp_d);
        chk("l1_miss_pulses", miss_pulses, exp_hit ? 0 : 1);
        chk("mem_req_cycles", memreq_cycles, (!exp_hit && exp_lat > 3) ? md + 1 : 0);
        @(negedge clk);
        chk("valid_one_cycle", {31'd0, cpu_valid}, 32'd0);
        chk("data_holds", cpu_data, exp_d);
        chk("hit_count", {16'd0, hit_count}, {16'd0, m_hits});
        chk("miss_count", {16'd0, miss_count}, {16'd0, m_misses});
    endtask

    task automatic rand_txn();
        logic [10:0] a;
        int mode, md;
        logic [31:0] l2d, memd, ed;
        logic eh;
        int el;
        a = {$urandom_range(3, 0) == 0 ? 4'd0 : 4'($urandom_range(3, 1)), 2'($urandom_range(3, 0)),
             5'($urandom_range(31, 0))};
        mode = $urandom_range(3, 0);
        md = $urandom_range(6, 0);
        l2d = $urandom; memd = $urandom;
        model_access(a, mode, l2d, md, memd, eh, ed, el);
        run_txn(a, mode, l2d, md, memd, eh, ed, el);
    endtask

    initial begin
        logic eh;
        logic [31:0] ed;
        int el, nvalid, seen;

        tbl[0] = '{11'h0A0, 1, 32'h0, 4, 32'hFEEDFACE, 1'b0, 32'hFEEDFACE, 8};
        tbl[1] = '{11'h0A0, 1, 32'h0, 0, 32'h0,        1'b1, 32'hFEEDFACE, 1};
        tbl[2] = '{11'h120, 0, 32'h12345678, 0, 32'h0, 1'b0, 32'h12345678, 3};
        tbl[3] = '{11'h0A0, 2, 32'h0, 0, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF, 4};
        tbl[4] = '{11'h0E0, 3, 32'hCAFEF00D, 2, 32'h1, 1'b0, 32'hCAFEF00D, 3};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_valid", {31'd0, cpu_valid}, 32'd0);
        chk("rst_l1_miss", {31'd0, l1_miss}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_data", cpu_data, 32'd0);
        chk("rst_counts", {hit_count, miss_count}, 32'd0);
        chk("rst_l2_addr", {21'd0, l2_addr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            model_access(tbl[i].addr, tbl[i].mode, tbl[i].l2d, tbl[i].md, tbl[i].memd, eh, ed, el);
            run_txn(tbl[i].addr, tbl[i].mode, tbl[i].l2d, tbl[i].md, tbl[i].memd,
                    tbl[i].exp_hit, tbl[i].exp_d, tbl[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) rand_txn();

        // Back-to-back: cpu_req held over four accepted hits on a resident line.
        model_access(11'h0A4, 0, 32'h5A5A5A5A, 0, 32'h0, eh, ed, el);
        run_txn(11'h0A4, 0, 32'h5A5A5A5A, 0, 32'h0, eh, ed, el);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 11'h0A4;
        @(negedge clk);
        nvalid = 0;
        for (int c = 0; c < 9; c++) begin
            chk("b2b_valid", {31'd0, cpu_valid}, {31'd0, (c % 2 == 1 && c <= 7)});
            if (cpu_valid) begin
                nvalid++;
                chk("b2b_hit", {31'd0, cpu_hit}, 32'd1);
                chk("b2b_data", cpu_data, ed);
            end
            if (c == 6) cpu_req = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) model_access(11'h0A4, 0, 32'h0, 0, 32'h0, eh, ed, el);
        chk("b2b_count", nvalid, 4);
        chk("b2b_hit_count", {16'd0, hit_count}, {16'd0, m_hits});

        // Saturation: preload the hit counter just below its ceiling.
        force dut.hit_count_r = 16'hFFFD;
        @(negedge clk);
        release dut.hit_count_r;
        @(negedge clk);
        chk("sat_preload", {16'd0, hit_count}, 32'h0000FFFD);
        m_hits = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            model_access(11'h0A4, 0, 32'h0, 0, 32'h0, eh, ed, el);
            run_txn(11'h0A4, 0, 32'h0, 0, 32'h0, eh, ed, el);
        end
        chk("sat_final", {16'd0, hit_count}, 32'h0000FFFF);

        // Reset while waiting on memory.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 11'h040;
        @(negedge clk);
        cpu_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            l2_miss = (c == 2);
            if (mem_req) seen++;
            @(negedge clk);
        end
        l2_miss = 1'b0;
        chk("mw_mem_req_seen", seen, 3);
        rst_n = 1'b0;
        #1;
        chk("mw_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mw_rst_ready", {31'd0, cpu_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mw_rst_no_valid", {31'd0, cpu_valid}, 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        chk("mw_rst_counts", {hit_count, miss_count}, 32'd0);
        model_access(11'h0A4, 0, 32'h77665544, 0, 32'h0, eh, ed, el);
        chk("mw_model_miss", {31'd0, eh}, 32'd0);
        run_txn(11'h0A4, 0, 32'h77665544, 0, 32'h0, eh, ed, el);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
